// File: rtl/axi_bridge_pkg.sv
// Shared types for the AXI bridge: B-channel response codes, the write-route
// entry stored per outstanding AW, and a response classification helper.
package axi_bridge_pkg;

    // Route entries are sized for the widest configuration in use; narrower
    // instances zero-extend into them and the constant bits are trimmed.
    localparam int unsigned ROUTE_SEL_W = 8;
    localparam int unsigned ROUTE_ID_W  = 16;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef struct packed {
        logic [ROUTE_SEL_W-1:0] sel;
        logic [ROUTE_ID_W-1:0]  id;
    } route_t;

    // SLVERR and DECERR both have bit 1 set.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/wresp_route_fifo.sv
// In-order synchronous FIFO holding one route entry per accepted AW.
// Ports: clk, rst (sync active-high), push/push_data, pop,
//        full/empty (registered), head (entry at the read pointer).
// A push while full is dropped unless a pop happens in the same cycle.
module wresp_route_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_wresp_router.sv
// Routes B responses from NUM_SLAVES slaves back to master M1 in AW order.
// Ports: ACLK/ARESET (sync active-high); aw_push/aw_sel/aw_id enqueue a
//        route, aw_full back-pressures the AW decoder; w_done counts
//        completed write bursts; BID/BRESP/BVALID/BREADY_M1 is the registered
//        master B port; BID_S/BRESP_S/BVALID_S/BREADY_S are the packed slave
//        B ports (BREADY_S is combinational); stop/stop_clr is the sticky
//        error flag. Select values >= NUM_SLAVES answer DECERR locally.
// Option: define WRESP_ID_CHECK_EN to replace a slave response whose BID
//         disagrees with the recorded AWID by SLVERR on the recorded ID.
module axi_wresp_router
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned IDS_W      = 8,
    parameter int unsigned SEL_W      = $clog2(NUM_SLAVES + 1)
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        aw_push,
    input  logic [SEL_W-1:0]            aw_sel,
    input  logic [ID_W-1:0]             aw_id,
    output logic                        aw_full,
    input  logic                        w_done,
    output logic [ID_W-1:0]             BID_M1,
    output logic [1:0]                  BRESP_M1,
    output logic                        BVALID_M1,
    input  logic                        BREADY_M1,
    input  logic [NUM_SLAVES*IDS_W-1:0] BID_S,
    input  logic [NUM_SLAVES*2-1:0]     BRESP_S,
    input  logic [NUM_SLAVES-1:0]       BVALID_S,
    output logic [NUM_SLAVES-1:0]       BREADY_S,
    output logic                        stop,
    input  logic                        stop_clr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    route_t                     push_ent, head;
    logic [$bits(route_t)-1:0]  head_raw;
    logic                       fifo_full, fifo_empty;

    logic [IDS_W-1:0]           bid_s_arr   [NUM_SLAVES];
    logic [1:0]                 bresp_s_arr [NUM_SLAVES];

    logic [CNT_W-1:0]           wcnt_q, wcnt_d;
    logic                       obuf_valid_q, obuf_valid_d;
    logic [ID_W-1:0]            bid_q, bid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       stop_q, stop_d;

    logic                       eligible, can_load, head_dflt;
    logic                       real_load, dflt_load, load;
    logic [NUM_SLAVES-1:0]      bready_s_c;
    logic [IDS_W-1:0]           slv_bid;
    logic [1:0]                 slv_resp;
    logic [ID_W-1:0]            load_id;
    logic [1:0]                 load_resp;

    assign push_ent = '{sel: ROUTE_SEL_W'(aw_sel), id: ROUTE_ID_W'(aw_id)};
    assign head     = route_t'(head_raw);

    wresp_route_fifo #(
        .WIDTH ($bits(route_t)),
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (aw_push),
        .push_data (push_ent),
        .pop       (load),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_raw)
    );

    // Unpack the slave B buses.
    always_comb begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            bid_s_arr[i]   = BID_S[i*IDS_W +: IDS_W];
            bresp_s_arr[i] = BRESP_S[i*2 +: 2];
        end
    end

    // Head-of-queue mux, load decision and next-state of wcnt/obuf/stop.
    always_comb begin
        eligible   = !fifo_empty && (wcnt_q != '0);
        can_load   = eligible && (!obuf_valid_q || BREADY_M1);
        head_dflt  = (head.sel >= ROUTE_SEL_W'(NUM_SLAVES));
        bready_s_c = '0;
        real_load  = 1'b0;
        slv_bid    = '0;
        slv_resp   = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (can_load && !head_dflt && (head.sel == ROUTE_SEL_W'(i))) begin
                bready_s_c[i] = 1'b1;
                if (BVALID_S[i]) begin
                    real_load = 1'b1;
                    slv_bid   = bid_s_arr[i];
                    slv_resp  = bresp_s_arr[i];
                end
            end
        end
        dflt_load = can_load && head_dflt;
        load      = real_load || dflt_load;

        load_id   = ID_W'(slv_bid);
        load_resp = slv_resp;
`ifdef WRESP_ID_CHECK_EN
        // A slave answering with the wrong ID is reported on the expected ID.
        if (real_load && (ID_W'(slv_bid) != ID_W'(head.id))) begin
            load_id   = ID_W'(head.id);
            load_resp = RESP_SLVERR;
        end
`endif
        if (dflt_load) begin
            load_id   = ID_W'(head.id);
            load_resp = RESP_DECERR;
        end

        // Completed W bursts not yet answered; saturates at DEPTH.
        wcnt_d = wcnt_q;
        if (w_done && !load) begin
            if (wcnt_q != CNT_W'(DEPTH)) begin
                wcnt_d = wcnt_q + CNT_W'(1);
            end
        end else if (!w_done && load) begin
            wcnt_d = wcnt_q - CNT_W'(1);
        end

        // One-entry output buffer; payload returns to zero once drained.
        obuf_valid_d = obuf_valid_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        if (load) begin
            obuf_valid_d = 1'b1;
            bid_d        = load_id;
            bresp_d      = load_resp;
        end else if (obuf_valid_q && BREADY_M1) begin
            obuf_valid_d = 1'b0;
            bid_d        = '0;
            bresp_d      = '0;
        end

        // Set beats clear when both happen together.
        stop_d = stop_q;
        if (stop_clr) begin
            stop_d = 1'b0;
        end
        if (load && is_err_resp(load_resp)) begin
            stop_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wcnt_q       <= '0;
            obuf_valid_q <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= '0;
            stop_q       <= 1'b0;
        end else begin
            wcnt_q       <= wcnt_d;
            obuf_valid_q <= obuf_valid_d;
            bid_q        <= bid_d;
            bresp_q      <= bresp_d;
            stop_q       <= stop_d;
        end
    end

    assign aw_full   = fifo_full;
    assign BVALID_M1 = obuf_valid_q;
    assign BID_M1    = bid_q;
    assign BRESP_M1  = bresp_q;
    assign BREADY_S  = bready_s_c;
    assign stop      = stop_q;

endmodule
